// File: rtl/bus_bridge_if.sv
// CPU-side data bus: byte address, write strobe, write data and
// zero-latency read data returned from the bridge.
interface bus_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  // CPU side: drives address/strobe/data, consumes read data
  modport master (
    output Bus_addr,
    output Bus_wen,
    output Bus_wdata,
    input  Bus_rdata
  );

  // Bridge side: consumes address/strobe/data, returns read data
  modport slave (
    input  Bus_addr,
    input  Bus_wen,
    input  Bus_wdata,
    output Bus_rdata
  );
endinterface

// File: rtl/bus_bridge.sv
// Single-cycle CPU bus bridge: splits the address space between an
// external DRAM and a small peripheral block (7-segment display register,
// free-running timer, LEDs, switches). Reads are combinational so the core
// sees data in the same cycle it presents the address.
module bus_bridge #(
  parameter int unsigned SCAN_DIV = 2000
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  bus_bridge_if.slave   bus,
  output logic [13:0]   dram_addr,
  output logic          dram_wen,
  output logic [31:0]   dram_wdata,
  input  logic [31:0]   dram_rdata,
  input  logic [23:0]   sw,
  output logic [23:0]   led,
  output logic [7:0]    seg_en,
  output logic [7:0]    seg_data
);

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DIG    = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;

  // SCAN_DIV is at least 2, so the counter is always at least one bit wide
  localparam int unsigned     CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Active-low hex decode, segments {dp,g,f,e,d,c,b,a}, dp always off
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      4'hF:    code = 8'h8E;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  // Select the nibble of the display register shown on digit idx
  function automatic logic [3:0] dig_nibble(input logic [31:0] dig, input logic [2:0] idx);
    return dig[{idx, 2'b00} +: 4];
  endfunction

  logic             periph_sel_s;
  logic             sel_dig_s;
  logic             sel_timer_s;
  logic             sel_led_s;
  logic             sel_sw_s;
  logic [31:0]      rdata_s;

  logic [31:0]      dig_q, dig_d;
  logic [31:0]      timer_q, timer_d;
  logic [23:0]      led_q, led_d;
  logic [23:0]      sw_meta_q, sw_meta_d;
  logic [23:0]      sw_sync_q, sw_sync_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic [7:0]       seg_en_q, seg_en_d;
  logic [7:0]       seg_data_q, seg_data_d;

  // Address decode: top 4 KiB is peripheral space, everything else is DRAM
  always_comb begin
    periph_sel_s = (bus.Bus_addr >= PERIPH_BASE);
    sel_dig_s    = (bus.Bus_addr == ADDR_DIG);
    sel_timer_s  = (bus.Bus_addr == ADDR_TIMER);
    sel_led_s    = (bus.Bus_addr == ADDR_LED);
    sel_sw_s     = (bus.Bus_addr == ADDR_SW);
  end

  // Zero-latency read mux; unmapped peripheral addresses read as zero
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (!periph_sel_s) begin
      rdata_s = dram_rdata;
    end else if (sel_dig_s) begin
      rdata_s = dig_q;
    end else if (sel_timer_s) begin
      rdata_s = timer_q;
    end else if (sel_led_s) begin
      rdata_s = {8'h00, led_q};
    end else if (sel_sw_s) begin
      rdata_s = {8'h00, sw_sync_q};
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.Bus_rdata = rdata_s;

  // DRAM pass-through; the reset does not touch this path
  always_comb begin
    dram_addr  = bus.Bus_addr[15:2];
    dram_wdata = bus.Bus_wdata;
    dram_wen   = bus.Bus_wen & ~periph_sel_s;
  end

  // Peripheral register next-state: bus writes, timer increment, switch sync
  always_comb begin
    dig_d     = dig_q;
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
    if (bus.Bus_wen && sel_dig_s) begin
      dig_d = bus.Bus_wdata;
    end else begin
      dig_d = dig_q;
    end
    if (bus.Bus_wen && sel_led_s) begin
      led_d = bus.Bus_wdata[23:0];
    end else begin
      led_d = led_q;
    end
    // A bus write to the timer overrides that cycle's increment
    if (bus.Bus_wen && sel_timer_s) begin
      timer_d = bus.Bus_wdata;
    end else begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Display scan: dwell SCAN_DIV cycles per digit, then step to the next digit
  always_comb begin
    scan_cnt_d  = scan_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == CNT_LAST) begin
      scan_cnt_d  = {CNT_W{1'b0}};
      digit_idx_d = digit_idx_q + 3'd1;
    end else begin
      scan_cnt_d  = scan_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      digit_idx_d = digit_idx_q;
    end
    // Registered outputs follow the next index/content so they stay aligned
    seg_en_d   = ~(8'h01 << digit_idx_d);
    seg_data_d = hex_to_seg(dig_nibble(dig_d, digit_idx_d));
  end

  // State register with synchronous reset taking priority over all updates
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_q       <= 32'h0000_0000;
      timer_q     <= 32'h0000_0000;
      led_q       <= 24'h00_0000;
      sw_meta_q   <= 24'h00_0000;
      sw_sync_q   <= 24'h00_0000;
      scan_cnt_q  <= {CNT_W{1'b0}};
      digit_idx_q <= 3'd0;
      seg_en_q    <= 8'hFE;
      seg_data_q  <= 8'hC0;
    end else begin
      dig_q       <= dig_d;
      timer_q     <= timer_d;
      led_q       <= led_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_en_q    <= seg_en_d;
      seg_data_q  <= seg_data_d;
    end
  end

  assign led      = led_q;
  assign seg_en   = seg_en_q;
  assign seg_data = seg_data_q;

endmodule
